// File: rtl/chip_bus_pkg.sv
// Shared definitions for the chip's picorv32-style native memory bus:
// arbiter state encoding, bus widths and the default error read word.
package chip_bus_pkg;

    localparam int unsigned BUS_ADDR_W   = 32;
    localparam int unsigned BUS_DATA_W   = 32;
    localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } bus_state_t;

endpackage

// File: rtl/bus_watchdog.sv
// Loadable down-counter used to bound bus access duration; expired is
// asserted while the count sits at zero.
module bus_watchdog #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one native memory bus between two masters,
// with a watchdog that completes unacknowledged accesses with an error word.
module mem_bus_arbiter
    import chip_bus_pkg::*;
#(
    parameter int unsigned       ADDR_W   = BUS_ADDR_W,
    parameter int unsigned       DATA_W   = BUS_DATA_W,
    parameter int unsigned       TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(BUS_ERR_DATA)
) (
    input  logic                clk,
    input  logic                reset_async,
    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          grant,
    output logic                timeout_pulse,
    output logic [7:0]          err_count
);

    localparam logic [15:0] WD_LOAD = 16'(TIMEOUT - 1);

    bus_state_t state;
    logic [1:0] rst_sync;
    logic       rst_n;
    logic       last;
    logic       sel_valid;
    logic       done_ok;
    logic       err_ret;
    logic       expired;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    always_comb begin
        sel_valid = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        if (grant[0]) begin
            sel_valid = m0_valid;
            s_addr    = m0_addr;
            s_wdata   = m0_wdata;
            s_wstrb   = m0_wstrb;
        end else if (grant[1]) begin
            sel_valid = m1_valid;
            s_addr    = m1_addr;
            s_wdata   = m1_wdata;
            s_wstrb   = m1_wstrb;
        end
    end

    assign s_valid       = (state == BUSY) && sel_valid;
    assign done_ok       = s_valid && s_ready;
    assign err_ret       = (state == ERR);
    assign timeout_pulse = err_ret;
    assign m0_ready      = grant[0] && (done_ok || err_ret);
    assign m1_ready      = grant[1] && (done_ok || err_ret);
    assign m0_rdata      = !m0_ready ? '0 : (err_ret ? ERR_DATA : s_rdata);
    assign m1_rdata      = !m1_ready ? '0 : (err_ret ? ERR_DATA : s_rdata);

    bus_watchdog #(
        .WIDTH (16)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (err_ret),
        .load       (state == IDLE),
        .enable     (state == BUSY),
        .load_value (WD_LOAD),
        .expired    (expired)
    );

    // A completing slave ready takes priority over a watchdog expiry in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            last      <= 1'b1;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid && m1_valid) begin
                        grant <= last ? 2'b01 : 2'b10;
                        state <= BUSY;
                    end else if (m0_valid) begin
                        grant <= 2'b01;
                        state <= BUSY;
                    end else if (m1_valid) begin
                        grant <= 2'b10;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!sel_valid) begin
                        grant <= '0;
                        state <= IDLE;
                    end else if (s_ready) begin
                        last  <= grant[1];
                        grant <= '0;
                        state <= IDLE;
                    end else if (expired) begin
                        state <= ERR;
                    end
                end
                ERR: begin
                    last  <= grant[1];
                    grant <= '0;
                    state <= IDLE;
                    if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a latency-programmable slave model and
// a completion scoreboard checked whenever a master sees ready.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_async;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  grant;
    logic        timeout_pulse;
    logic [7:0]  err_count;

    typedef struct {
        int          m;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc_n = 0;
    int          grant_cyc = 0;
    int          ready_cyc = 0;
    logic        ready_tp = 1'b0;
    int          tp_count = 0;
    bit          done0 = 0;
    bit          done1 = 0;
    int          slv_lat = 0;
    int          slv_cnt = 0;
    logic [31:0] slv_key = '0;
    logic [1:0]  prev_grant = '0;
    int          exp_err = 0;
    int          tp_base;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk           (clk),
        .reset_async   (reset_async),
        .m0_valid      (m0_valid),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_wstrb      (m0_wstrb),
        .m0_ready      (m0_ready),
        .m0_rdata      (m0_rdata),
        .m1_valid      (m1_valid),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_wstrb      (m1_wstrb),
        .m1_ready      (m1_ready),
        .m1_rdata      (m1_rdata),
        .s_valid       (s_valid),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_wstrb       (s_wstrb),
        .s_ready       (s_ready),
        .s_rdata       (s_rdata),
        .grant         (grant),
        .timeout_pulse (timeout_pulse),
        .err_count     (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input int m, input logic [31:0] d);
        exp_t e;
        e.m     = m;
        e.rdata = d;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int m, input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            cyc();
            if ((m == 0) ? done0 : done1) got = 1;
        end
        chk($sformatf("done_m%0d", m), {31'b0, got}, 32'd1);
        if (m == 0) done0 = 0;
        else done1 = 0;
    endtask

    task automatic wait_any(input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            cyc();
            if (done0 || done1) got = 1;
        end
        chk("done_any", {31'b0, got}, 32'd1);
        done0 = 0;
        done1 = 0;
    endtask

    always @(posedge clk) cyc_n++;

    // Slave answers in the slv_lat-th cycle of s_valid (0 = never), data = addr ^ key.
    always @(posedge clk) begin
        #3;
        if (s_valid) begin
            slv_cnt++;
            if (slv_lat != 0 && slv_cnt == slv_lat) begin
                s_ready = 1'b1;
                s_rdata = s_addr ^ slv_key;
            end else begin
                s_ready = 1'b0;
                s_rdata = '0;
            end
        end else begin
            slv_cnt = 0;
            s_ready = 1'b0;
            s_rdata = '0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (grant != 2'b00 && prev_grant == 2'b00) grant_cyc = cyc_n;
        prev_grant = grant;
        if (timeout_pulse) tp_count++;
        if (m0_ready || m1_ready) begin
            ready_cyc = cyc_n;
            ready_tp  = timeout_pulse;
            chk("single_ready", {31'b0, m0_ready & m1_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", {30'b0, m1_ready, m0_ready}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ready_master", m1_ready ? 1 : 0, e.m);
                chk("ready_rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
                chk("idle_rdata", m1_ready ? m0_rdata : m1_rdata, 32'd0);
            end
            if (m0_ready) done0 = 1;
            else done1 = 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset_async = 1'b0;
        m0_valid = 0; m1_valid = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        m0_wstrb = '0; m1_wstrb = '0;
        repeat (2) cyc();
        #1;
        chk("rst_grant", {30'b0, grant}, 32'd0);
        chk("rst_s_valid", {31'b0, s_valid}, 32'd0);
        chk("rst_m0_ready", {31'b0, m0_ready}, 32'd0);
        chk("rst_m1_ready", {31'b0, m1_ready}, 32'd0);
        chk("rst_tp", {31'b0, timeout_pulse}, 32'd0);
        chk("rst_err", {24'b0, err_count}, 32'd0);
        reset_async = 1'b1;
        repeat (3) cyc();

        // single read by m0
        slv_key = 32'h12345678 ^ 32'h100;
        slv_lat = 3;
        m0_addr = 32'h100; m0_wstrb = 4'h0; m0_valid = 1;
        push(0, 32'h12345678);
        cyc(); #1;
        chk("t1_grant", {30'b0, grant}, 32'd1);
        chk("t1_s_valid", {31'b0, s_valid}, 32'd1);
        chk("t1_s_addr", s_addr, 32'h100);
        chk("t1_s_wstrb", {28'b0, s_wstrb}, 32'd0);
        wait_done(0, 20);
        m0_valid = 0; #1;
        chk("t1_latency", ready_cyc - grant_cyc, 32'd2);
        chk("t1_grant_idle", {30'b0, grant}, 32'd0);
        chk("t1_ready_pulse", {31'b0, m0_ready}, 32'd0);

        // m1 write while m0 waits
        slv_key = '0;
        slv_lat = 4;
        m1_addr = 32'h200; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'b0011; m1_valid = 1;
        push(1, 32'h200);
        push(0, 32'h300);
        cyc();
        m0_addr = 32'h300; m0_wstrb = 4'h0; m0_valid = 1; #1;
        chk("t3_grant", {30'b0, grant}, 32'd2);
        chk("t3_s_addr", s_addr, 32'h200);
        chk("t3_s_wdata", s_wdata, 32'hA5A5A5A5);
        chk("t3_s_wstrb", {28'b0, s_wstrb}, 32'h3);
        cyc(); #1;
        chk("t3_m0_stalled", {30'b0, grant}, 32'd2);
        chk("t3_m0_no_ready", {31'b0, m0_ready}, 32'd0);
        chk("t3_s_wdata2", s_wdata, 32'hA5A5A5A5);
        wait_done(1, 20);
        m1_valid = 0;
        wait_done(0, 20);
        m0_valid = 0;

        // slave never answers: watchdog error completion
        slv_lat = 0;
        tp_base = tp_count;
        m0_addr = 32'h400; m0_valid = 1;
        push(0, 32'hDEADBEEF);
        exp_err = exp_err + 1;
        wait_done(0, 30);
        m0_valid = 0; #1;
        chk("t4_latency", ready_cyc - grant_cyc, 32'd8);
        chk("t4_tp_at_ready", {31'b0, ready_tp}, 32'd1);
        chk("t4_tp_width", tp_count - tp_base, 32'd1);
        chk("t4_tp_after", {31'b0, timeout_pulse}, 32'd0);
        chk("t4_err_count", {24'b0, err_count}, exp_err);

        // ready on the timeout boundary cycle wins
        slv_lat = 8;
        slv_key = 32'h0F0F0000;
        tp_base = tp_count;
        m0_addr = 32'h500; m0_valid = 1;
        push(0, 32'h500 ^ 32'h0F0F0000);
        wait_done(0, 30);
        m0_valid = 0; #1;
        chk("t5_latency", ready_cyc - grant_cyc, 32'd7);
        chk("t5_tp_at_ready", {31'b0, ready_tp}, 32'd0);
        chk("t5_tp_count", tp_count - tp_base, 32'd0);
        chk("t5_err_count", {24'b0, err_count}, exp_err);

        // reset mid-BUSY, pending m1 granted after release
        slv_lat = 0;
        m0_addr = 32'h600; m0_valid = 1;
        cyc(); cyc();
        m1_addr = 32'h700; m1_valid = 1;
        cyc();
        reset_async = 1'b0; #1;
        exp_err = 0;
        chk("t6_grant", {30'b0, grant}, 32'd0);
        chk("t6_s_valid", {31'b0, s_valid}, 32'd0);
        chk("t6_m0_ready", {31'b0, m0_ready}, 32'd0);
        chk("t6_m1_ready", {31'b0, m1_ready}, 32'd0);
        chk("t6_tp", {31'b0, timeout_pulse}, 32'd0);
        chk("t6_err", {24'b0, err_count}, exp_err);
        m0_valid = 0;
        cyc();
        reset_async = 1'b1;
        slv_lat = 2;
        slv_key = '0;
        push(1, 32'h700);
        wait_done(1, 20);
        m1_valid = 0;

        // both masters held from reset: 01,10,01,10
        reset_async = 1'b0;
        slv_lat = 2;
        slv_key = 32'hCAFE0000;
        m0_addr = 32'h10; m1_addr = 32'h20;
        m0_valid = 1; m1_valid = 1;
        push(0, 32'h10 ^ 32'hCAFE0000);
        push(1, 32'h20 ^ 32'hCAFE0000);
        push(0, 32'h10 ^ 32'hCAFE0000);
        push(1, 32'h20 ^ 32'hCAFE0000);
        cyc();
        reset_async = 1'b1;
        exp_err = 0;
        for (int i = 0; i < 4; i++) wait_any(30);
        m0_valid = 0; m1_valid = 0;
        cyc();

        // err_count saturation
        slv_lat = 0;
        m0_addr = 32'h800; m0_valid = 1;
        for (int i = 0; i < 300; i++) push(0, 32'hDEADBEEF);
        for (int i = 0; i < 300; i++) begin
            wait_done(0, 30);
            if (exp_err < 255) exp_err = exp_err + 1;
        end
        m0_valid = 0; #1;
        chk("t7_err_sat", {24'b0, err_count}, exp_err);
        repeat (3) cyc();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
